pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low; clears all state immediately.
REQ-003 PCReset  input  1  synchronous active-low PC clear.
REQ-004 PCWrite  input  1  absolute redirect request (PC <= JumpTarget).
REQ-005 PCIncrement  input  1  relative advance request.
REQ-006 PCImmediate  input  8  signed two's-complement displacement for PCIncrement.
REQ-007 JumpTarget  input  16  absolute target, taken from a register operand.
REQ-008 CondEn  input  1  1 = redirect is conditional on Cond; 0 = unconditional.
REQ-009 Cond  input  4  condition code.
REQ-010 PSR  input  5  flags: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
REQ-011 LinkWrite  input  1  capture return address on a taken redirect.
REQ-012 IRReset  input  1  synchronous active-low IR clear.
REQ-013 IRWrite  input  1  load IR from MemData.
REQ-014 MemData  input  16  instruction word from memory.
REQ-015 PC  output  16  current program counter, registered.
REQ-016 INS  output  16  instruction register, registered; feeds the controller.
REQ-017 Link  output  16  return-address register.
REQ-018 BranchTaken  output  1  registered one-cycle pulse after a taken non-sequential redirect.

Function
REQ-019 taken SHALL be ~CondEn | cond_true(Cond, PSR).
- cond_true table: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 HI L; 5 LS ~L; 6 GT N; 7 LE ~N; 8 FS F; 9 FC ~F.
- A LO ~L&~Z; B HS L|Z; C LT ~N&~Z; D GE N|Z; E UC 1; F never 0.
REQ-020 PC update priority, one clock edge: PCReset=0 -> 0x0000.
- Else PCWrite=1 -> taken ? JumpTarget : PC+1.
- Else PCIncrement=1 -> taken ? PC+sext16(PCImmediate) : PC+1.
- Else PC holds.
REQ-021 PC arithmetic SHALL be modulo 2^16: 0xFFFF+1 = 0x0000; 0x0000+sext(0xFF) = 0xFFFF.
REQ-022 Link SHALL load PC+1 (pre-update PC) when LinkWrite=1, (PCWrite|PCIncrement)=1, taken=1 and PCReset=1; otherwise it holds.
REQ-023 BranchTaken SHALL be 1 for exactly the cycle after an edge where taken=1 and either PCWrite=1, or (PCIncrement=1 and PCImmediate != 0x01); otherwise 0.
REQ-024 IR priority: IRReset=0 -> 0x0000; else IRWrite=1 -> MemData; else hold.
REQ-025 IR and PC updates SHALL be independent; simultaneous IRWrite and PC update both take effect on the same edge.
REQ-026 Latency: every output reflects inputs sampled at edge N from edge N onward; there is no combinational input-to-output path.
REQ-027 PSR and Cond SHALL be sampled only on the updating edge; PSR changes while PCWrite=PCIncrement=0 have no effect.

Reset
REQ-028 Reset=0 SHALL immediately force PC=0x0000, INS=0x0000, Link=0x0000 and BranchTaken=0, regardless of Clock.
REQ-029 Reset asserted mid-redirect SHALL discard the pending update; the first edge after release follows REQ-020 normally.
REQ-030 PCReset and IRReset SHALL affect only PC and INS respectively; Link is cleared only by Reset.

Structure
REQ-031 A shared package SHALL hold the 4-bit condition-code constants (EQ..never), the PSR bit-index constants (C, L, F, Z, N) and PC width 16.
REQ-032 Condition evaluation SHALL be a separate combinational sub-module, branch_cond_eval (Cond, PSR -> cond_true).

Verification
REQ-033 Reset release; PCIncrement=1, PCImmediate=0x01 for 3 edges -> PC 1,2,3; BranchTaken stays 0.
REQ-034 PC=0x0010, PCIncrement=1, PCImmediate=0xFC, CondEn=1, Cond=EQ:
- with Z=1 -> PC=0x000C and BranchTaken=1 for one cycle;
- with Z=0 -> PC=0x0011 and BranchTaken=0.
REQ-035 PC=0x0020, PCWrite=1, JumpTarget=0x1234, LinkWrite=1, CondEn=0 -> PC=0x1234, Link=0x0021, BranchTaken pulse.
REQ-036 PC=0xFFFF, PCIncrement=1, PCImmediate=0x01 -> PC=0x0000; and PC=0x0000 with PCImmediate=0xFF, taken -> PC=0xFFFF.
REQ-037 All 16 Cond values against PSR patterns 0x00, 0x1F, 0x0A (L=1, Z=1) and 0x10 (N=1) -> taken matches the REQ-019 table.
REQ-038 IRWrite=1 with MemData=0xA5C3 and simultaneous PCReset=0 -> INS=0xA5C3, PC=0x0000; Reset pulsed low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: condition codes, PSR flag indices and PC width shared by the fetch unit
package pc_fetch_unit_pkg;
  localparam int PC_W = 16;
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control, operand and register-output bundle of the fetch unit
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;
  logic            PCReset;
  logic            PCWrite;
  logic            PCIncrement;
  logic [7:0]      PCImmediate;
  logic [PC_W-1:0] JumpTarget;
  logic            CondEn;
  logic [3:0]      Cond;
  logic [4:0]      PSR;
  logic            LinkWrite;
  logic            IRReset;
  logic            IRWrite;
  logic [15:0]     MemData;
  logic [PC_W-1:0] PC;
  logic [15:0]     INS;
  logic [PC_W-1:0] Link;
  logic            BranchTaken;
  modport master(
    output PCReset, PCWrite, PCIncrement, PCImmediate, JumpTarget, CondEn, Cond, PSR,
           LinkWrite, IRReset, IRWrite, MemData,
    input  PC, INS, Link, BranchTaken
  );
  modport slave(
    input  PCReset, PCWrite, PCIncrement, PCImmediate, JumpTarget, CondEn, Cond, PSR,
           LinkWrite, IRReset, IRWrite, MemData,
    output PC, INS, Link, BranchTaken
  );
endinterface

// File: rtl/pc_fetch_unit_branch_cond_eval.sv
// branch_cond_eval: combinational condition-code test against the PSR flags
module branch_cond_eval
  import pc_fetch_unit_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [4:0] PSR,
  output logic       cond_true
);
  logic c, l, f, z, n;
  logic [15:0] truth;
  assign c = PSR[PSR_C];
  assign l = PSR[PSR_L];
  assign f = PSR[PSR_F];
  assign z = PSR[PSR_Z];
  assign n = PSR[PSR_N];
  // one bit per condition code, bit index == code value (EQ at bit 0 .. never at bit 15)
  assign truth = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                  ~n, n, ~l, l, ~c, c, ~z, z};
  assign cond_true = truth[Cond];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction register and link register with conditional redirects
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input logic          Clock,
  input logic          Reset,
  pc_fetch_unit_if.slave bus
);
  logic [PC_W-1:0] pc, link, pc_seq, pc_rel, pc_next;
  logic [15:0]     ins;
  logic            bt, cond_true, taken, redirect, link_en, bt_next;
  branch_cond_eval u_cond (
    .Cond      (bus.Cond),
    .PSR       (bus.PSR),
    .cond_true (cond_true)
  );
  assign taken    = ~bus.CondEn | cond_true;
  assign redirect = bus.PCWrite | bus.PCIncrement;
  assign pc_seq   = pc + 16'd1;
  assign pc_rel   = pc + {{8{bus.PCImmediate[7]}}, bus.PCImmediate};
  // PCReset beats PCWrite beats PCIncrement; an untaken redirect still steps sequentially
  always_comb
    pc_next = !bus.PCReset ? '0 :
              bus.PCWrite ? (taken ? bus.JumpTarget : pc_seq) :
              bus.PCIncrement ? (taken ? pc_rel : pc_seq) : pc;
  assign link_en = bus.LinkWrite & redirect & taken & bus.PCReset;
  // an increment of exactly +1 is sequential flow, not a branch
  assign bt_next = taken & (bus.PCWrite | (bus.PCIncrement & (bus.PCImmediate != 8'h01)));
  // PC, link and branch-pulse registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc   <= '0;
      link <= '0;
      bt   <= 1'b0;
    end else begin
      pc   <= pc_next;
      link <= link_en ? pc_seq : link;
      bt   <= bt_next;
    end
  end
  // instruction register, independent of the PC path
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ins <= '0;
    else ins <= !bus.IRReset ? 16'h0000 : bus.IRWrite ? bus.MemData : ins;
  end
  assign bus.PC          = pc;
  assign bus.INS         = ins;
  assign bus.Link        = link;
  assign bus.BranchTaken = bt;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int errors = 0;
  pc_fetch_unit_if bus ();
  pc_fetch_unit dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle;
    bus.PCReset = 1'b1;
    bus.PCWrite = 1'b0;
    bus.PCIncrement = 1'b0;
    bus.PCImmediate = 8'h01;
    bus.JumpTarget = 16'h0000;
    bus.CondEn = 1'b0;
    bus.Cond = 4'h0;
    bus.PSR = 5'h00;
    bus.LinkWrite = 1'b0;
    bus.IRReset = 1'b1;
    bus.IRWrite = 1'b0;
    bus.MemData = 16'h0000;
  endtask

  task automatic set_pc(input logic [15:0] v);
    idle();
    bus.PCWrite = 1'b1;
    bus.JumpTarget = v;
    tick();
    idle();
  endtask

  task automatic test_reset;
    idle();
    #1;
    checks++;
    if (bus.PC !== 16'h0 || bus.INS !== 16'h0 || bus.Link !== 16'h0 || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: PC=%h INS=%h Link=%h BT=%b, required all zero", bus.PC, bus.INS, bus.Link, bus.BranchTaken);
    end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_sequential;
    logic [15:0] exp_pc;
    idle();
    bus.PCIncrement = 1'b1;
    bus.PCImmediate = 8'h01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 16'(i);
      checks++;
      if (bus.PC !== exp_pc || bus.BranchTaken !== 1'b0) begin
        errors++;
        $display("FAIL seq_step%0d: PC=%h BT=%b, required PC=%h BT=0", i, bus.PC, bus.BranchTaken, exp_pc);
      end
    end
    idle();
  endtask

  task automatic test_cond_branch;
    set_pc(16'h0010);
    bus.PCIncrement = 1'b1;
    bus.PCImmediate = 8'hFC;
    bus.CondEn = 1'b1;
    bus.Cond = 4'h0;
    bus.PSR = 5'h08;
    tick();
    idle();
    checks++;
    if (bus.PC !== 16'h000C || bus.BranchTaken !== 1'b1) begin
      errors++;
      $display("FAIL cond_taken: PC=%h BT=%b, required PC=000c BT=1", bus.PC, bus.BranchTaken);
    end
    tick();
    checks++;
    if (bus.PC !== 16'h000C || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL cond_pulse_end: PC=%h BT=%b, required PC=000c BT=0", bus.PC, bus.BranchTaken);
    end
    set_pc(16'h0010);
    bus.PCIncrement = 1'b1;
    bus.PCImmediate = 8'hFC;
    bus.CondEn = 1'b1;
    bus.Cond = 4'h0;
    bus.PSR = 5'h00;
    tick();
    idle();
    checks++;
    if (bus.PC !== 16'h0011 || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL cond_not_taken: PC=%h BT=%b, required PC=0011 BT=0", bus.PC, bus.BranchTaken);
    end
  endtask

  task automatic test_jump_link;
    set_pc(16'h0020);
    bus.PCWrite = 1'b1;
    bus.JumpTarget = 16'h1234;
    bus.LinkWrite = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.PC !== 16'h1234 || bus.Link !== 16'h0021 || bus.BranchTaken !== 1'b1) begin
      errors++;
      $display("FAIL jump_link: PC=%h Link=%h BT=%b, required PC=1234 Link=0021 BT=1", bus.PC, bus.Link, bus.BranchTaken);
    end
    bus.PCWrite = 1'b1;
    bus.JumpTarget = 16'h5555;
    bus.LinkWrite = 1'b1;
    bus.CondEn = 1'b1;
    bus.Cond = 4'hF;
    tick();
    idle();
    checks++;
    if (bus.PC !== 16'h1235 || bus.Link !== 16'h0021 || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL jump_untaken: PC=%h Link=%h BT=%b, required PC=1235 Link=0021 BT=0", bus.PC, bus.Link, bus.BranchTaken);
    end
  endtask

  task automatic test_wrap;
    set_pc(16'hFFFF);
    bus.PCIncrement = 1'b1;
    bus.PCImmediate = 8'h01;
    tick();
    checks++;
    if (bus.PC !== 16'h0000 || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up: PC=%h BT=%b, required PC=0000 BT=0", bus.PC, bus.BranchTaken);
    end
    bus.PCImmediate = 8'hFF;
    tick();
    idle();
    checks++;
    if (bus.PC !== 16'hFFFF || bus.BranchTaken !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: PC=%h BT=%b, required PC=ffff BT=1", bus.PC, bus.BranchTaken);
    end
  endtask

  task automatic test_cond_table;
    logic [4:0]  psr_v [4] = '{5'h00, 5'h1F, 5'h0A, 5'h10};
    logic [15:0] mask_v [4] = '{16'h56AA, 16'h6955, 16'h6A99, 16'h666A};
    logic [15:0] cur, exp_pc, jt;
    logic        exp_t;
    set_pc(16'h0100);
    cur = 16'h0100;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 16; c++) begin
        jt = 16'h4000 + 16'(p * 16 + c) * 16'h10;
        exp_t = mask_v[p][c];
        exp_pc = exp_t ? jt : cur + 16'd1;
        bus.PCWrite = 1'b1;
        bus.CondEn = 1'b1;
        bus.Cond = 4'(c);
        bus.PSR = psr_v[p];
        bus.JumpTarget = jt;
        tick();
        checks++;
        if (bus.PC !== exp_pc || bus.BranchTaken !== exp_t) begin
          errors++;
          $display("FAIL cond_table psr=%h cond=%h: PC=%h BT=%b, required PC=%h BT=%b", psr_v[p], c, bus.PC, bus.BranchTaken, exp_pc, exp_t);
        end
        cur = exp_pc;
      end
    end
    idle();
    bus.PSR = 5'h1F;
    tick();
    checks++;
    if (bus.PC !== cur || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL psr_idle: PC=%h BT=%b, required PC=%h BT=0", bus.PC, bus.BranchTaken, cur);
    end
    idle();
  endtask

  task automatic test_ir;
    bus.IRWrite = 1'b1;
    bus.MemData = 16'hA5C3;
    bus.PCReset = 1'b0;
    tick();
    idle();
    checks++;
    if (bus.INS !== 16'hA5C3 || bus.PC !== 16'h0000 || bus.Link !== 16'h0021) begin
      errors++;
      $display("FAIL ir_pcreset: INS=%h PC=%h Link=%h, required INS=a5c3 PC=0000 Link=0021", bus.INS, bus.PC, bus.Link);
    end
    tick();
    checks++;
    if (bus.INS !== 16'hA5C3) begin
      errors++;
      $display("FAIL ir_hold: INS=%h, required a5c3", bus.INS);
    end
    bus.IRReset = 1'b0;
    bus.IRWrite = 1'b1;
    bus.MemData = 16'hFFFF;
    tick();
    idle();
    checks++;
    if (bus.INS !== 16'h0000 || bus.Link !== 16'h0021) begin
      errors++;
      $display("FAIL ir_reset: INS=%h Link=%h, required INS=0000 Link=0021", bus.INS, bus.Link);
    end
  endtask

  task automatic test_async_reset;
    bus.IRWrite = 1'b1;
    bus.MemData = 16'h1111;
    bus.PCWrite = 1'b1;
    bus.JumpTarget = 16'h0055;
    tick();
    bus.IRWrite = 1'b0;
    bus.JumpTarget = 16'h7777;
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.PC !== 16'h0 || bus.INS !== 16'h0 || bus.Link !== 16'h0 || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: PC=%h INS=%h Link=%h BT=%b, required all zero", bus.PC, bus.INS, bus.Link, bus.BranchTaken);
    end
    tick();
    checks++;
    if (bus.PC !== 16'h0 || bus.BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: PC=%h BT=%b, required PC=0000 BT=0", bus.PC, bus.BranchTaken);
    end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.PC !== 16'h7777 || bus.BranchTaken !== 1'b1 || bus.INS !== 16'h0) begin
      errors++;
      $display("FAIL post_reset: PC=%h BT=%b INS=%h, required PC=7777 BT=1 INS=0000", bus.PC, bus.BranchTaken, bus.INS);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_cond_branch();
    test_jump_link();
    test_wrap();
    test_cond_table();
    test_ir();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
